// File: rtl/fwd_operand_reg.sv
`default_nettype none
// ============================================================================
// Module      : fwd_operand_reg
// Description : Operand forwarding select feeding a 1-entry valid/ready slot.
//               Picks one of N forwarding sources with a one-hot select, or
//               the default (register-file) operand when the select is zero
//               or multi-hot, and registers the result together with
//               pc_plus_4. Multi-hot selects are flagged on sel_err.
//               Optional statistics counters: define FWD_OPERAND_STATS_EN.
// Ports       : clk, rst        - clock, asynchronous active-high reset
//               src_data[N*W]   - forwarding sources, source i at [i*W +: W]
//               src_sel[N]      - one-hot source select
//               dflt, pc_plus_4 - default operand, pc carried alongside
//               flush           - discard slot content at next edge
//               in_valid/ready  - upstream handshake
//               out_valid/ready - downstream handshake
//               out_data/out_pc - registered operand and pc
//               out_fwd/sel_err - operand was forwarded / select was illegal
//               fwd_cnt/err_cnt - (FWD_OPERAND_STATS_EN) transfer counters
// Revision    : 1.0 - initial release
// ============================================================================
module fwd_operand_reg #(
    parameter int W = 32,
    parameter int N = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N*W-1:0]   src_data,
    input  logic [N-1:0]     src_sel,
    input  logic [W-1:0]     dflt,
    input  logic [W-1:0]     pc_plus_4,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
    output logic [W-1:0]     out_pc,
    output logic             out_fwd,
    output logic             sel_err
`ifdef FWD_OPERAND_STATS_EN
    ,
    output logic [31:0]      fwd_cnt,
    output logic [31:0]      err_cnt
`endif
);

    localparam logic [0:0] c_ST_EMPTY = 1'b0;
    localparam logic [0:0] c_ST_FULL  = 1'b1;

    logic [0:0]   r_state;
    logic [0:0]   w_state_nxt;
    logic [W-1:0] r_data;
    logic [W-1:0] r_pc;
    logic         r_fwd;
    logic         r_err;

    logic         w_sel_any;
    logic         w_sel_multi;
    logic         w_sel_fwd;
    logic [W-1:0] w_fwd_data;
    logic [W-1:0] w_sel_data;
    logic         w_xfer_in;
    logic         w_load;

    // Walk the select once: any bit seen after the first marks multi-hot.
    // Data from every selected source is OR-ed; it is only used when exactly
    // one bit is set, so the OR never mixes sources on the forwarded path.
    always_comb begin
        w_sel_any   = 1'b0;
        w_sel_multi = 1'b0;
        w_fwd_data  = '0;
        for (int i = 0; i < N; i++) begin
            if (src_sel[i]) begin
                if (w_sel_any) begin
                    w_sel_multi = 1'b1;
                end
                w_sel_any  = 1'b1;
                w_fwd_data = w_fwd_data | src_data[i*W +: W];
            end
        end
    end

    assign w_sel_fwd  = w_sel_any & ~w_sel_multi;
    assign w_sel_data = w_sel_fwd ? w_fwd_data : dflt;

    assign in_ready  = (r_state == c_ST_EMPTY) | out_ready;
    assign w_xfer_in = in_valid & in_ready;
    // A flush in the same cycle drops the offered operand.
    assign w_load    = w_xfer_in & ~flush;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = c_ST_EMPTY;
        end else if (w_xfer_in) begin
            w_state_nxt = c_ST_FULL;
        end else if ((r_state == c_ST_FULL) && out_ready) begin
            w_state_nxt = c_ST_EMPTY;
        end
    end

    // Payload registers. Data and pc are left untouched by flush and drain;
    // consumers qualify them with out_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data <= '0;
            r_pc   <= '0;
            r_fwd  <= 1'b0;
            r_err  <= 1'b0;
        end else if (flush) begin
            r_fwd  <= 1'b0;
            r_err  <= 1'b0;
        end else if (w_xfer_in) begin
            r_data <= w_sel_data;
            r_pc   <= pc_plus_4;
            r_fwd  <= w_sel_fwd;
            r_err  <= w_sel_multi;
        end
    end

    assign out_valid = (r_state == c_ST_FULL);
    assign out_data  = r_data;
    assign out_pc    = r_pc;
    assign out_fwd   = r_fwd;
    assign sel_err   = r_err;

`ifdef FWD_OPERAND_STATS_EN
    logic [31:0] r_fwd_cnt;
    logic [31:0] r_err_cnt;

    // Counters wrap naturally; only reset clears them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fwd_cnt <= '0;
            r_err_cnt <= '0;
        end else if (w_load) begin
            if (w_sel_fwd) begin
                r_fwd_cnt <= r_fwd_cnt + 32'd1;
            end
            if (w_sel_multi) begin
                r_err_cnt <= r_err_cnt + 32'd1;
            end
        end
    end

    assign fwd_cnt = r_fwd_cnt;
    assign err_cnt = r_err_cnt;
`else
    // Only the counters consume the qualified load strobe.
    logic w_unused_load;
    assign w_unused_load = w_load;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fwd_operand_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_fwd_operand_reg
// Description : Self-checking bench for fwd_operand_reg (W=32, N=2).
//               Directed vector table, hand-written multi-cycle sequences
//               and a randomized run against a transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fwd_operand_reg;

    localparam int W = 32;
    localparam int N = 2;

    logic           clk;
    logic           rst;
    logic [N*W-1:0] src_data;
    logic [N-1:0]   src_sel;
    logic [W-1:0]   dflt;
    logic [W-1:0]   pc_plus_4;
    logic           flush;
    logic           in_valid;
    logic           in_ready;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_data;
    logic [W-1:0]   out_pc;
    logic           out_fwd;
    logic           sel_err;
`ifdef FWD_OPERAND_STATS_EN
    logic [31:0]    fwd_cnt;
    logic [31:0]    err_cnt;
`endif

    fwd_operand_reg #(.W(W), .N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .src_data  (src_data),
        .src_sel   (src_sel),
        .dflt      (dflt),
        .pc_plus_4 (pc_plus_4),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_pc    (out_pc),
        .out_fwd   (out_fwd),
        .sel_err   (sel_err)
`ifdef FWD_OPERAND_STATS_EN
        ,
        .fwd_cnt   (fwd_cnt),
        .err_cnt   (err_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: the slot is either empty or holds one item.
    bit          m_full;
    logic [31:0] m_data;
    logic [31:0] m_pc;
    bit          m_fwd;
    bit          m_err;
    int unsigned m_fwd_cnt;
    int unsigned m_err_cnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Selection rule: exactly one bit set forwards that source; anything
    // else yields the default, with multi-hot flagged as an error.
    task automatic model_select(input logic [1:0] sel, input logic [63:0] src,
                                input logic [31:0] df, output logic [31:0] d,
                                output bit f, output bit e);
        int ones;
        ones = $countones(sel);
        d = df;
        f = 1'b0;
        e = (ones > 1);
        if (ones == 1) begin
            f = 1'b1;
            for (int k = 0; k < 2; k++) begin
                if (sel[k]) d = src[k*32 +: 32];
            end
        end
    endtask

    task automatic model_reset();
        m_full = 0; m_data = '0; m_pc = '0; m_fwd = 0; m_err = 0;
        m_fwd_cnt = 0; m_err_cnt = 0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".out_valid"}, 64'(out_valid), 64'(m_full));
        chk({tag, ".out_data"},  64'(out_data),  64'(m_data));
        chk({tag, ".out_pc"},    64'(out_pc),    64'(m_pc));
        chk({tag, ".out_fwd"},   64'(out_fwd),   64'(m_fwd));
        chk({tag, ".sel_err"},   64'(sel_err),   64'(m_err));
`ifdef FWD_OPERAND_STATS_EN
        chk({tag, ".fwd_cnt"},   64'(fwd_cnt),   64'(m_fwd_cnt));
        chk({tag, ".err_cnt"},   64'(err_cnt),   64'(m_err_cnt));
`endif
    endtask

    // One clock cycle: drive inputs, check in_ready, clock, update model, check.
    // Called at posedge+1.
    task automatic step(input logic [1:0] sel, input logic [31:0] s0, input logic [31:0] s1,
                        input logic [31:0] df, input logic [31:0] pc,
                        input logic iv, input logic ordy, input logic fl);
        logic [31:0] d;
        bit f, e, rdy;
        src_sel   = sel;
        src_data  = {s1, s0};
        dflt      = df;
        pc_plus_4 = pc;
        in_valid  = iv;
        out_ready = ordy;
        flush     = fl;
        #1;
        rdy = !m_full || ordy;
        chk("in_ready", 64'(in_ready), 64'(rdy));
        @(posedge clk);
        model_select(sel, {s1, s0}, df, d, f, e);
        if (fl) begin
            m_full = 0; m_fwd = 0; m_err = 0;
        end else if (iv && rdy) begin
            m_full = 1; m_data = d; m_pc = pc; m_fwd = f; m_err = e;
            if (f) m_fwd_cnt++;
            if (e) m_err_cnt++;
        end else if (m_full && ordy) begin
            m_full = 0;
        end
        #1;
        check_outputs("step");
    endtask

    typedef struct {
        logic [1:0]  sel;
        logic [31:0] dflt;
        logic        iv;
        logic        fl;
        logic        exp_valid;
        logic [31:0] exp_data;
        logic        exp_fwd;
        logic        exp_err;
    } vec_t;

    vec_t vecs[6];

    initial begin
        // src0=0x11, src1=0x22, out_ready=1 throughout
        vecs[0] = '{2'b01, 32'h33, 1'b1, 1'b0, 1'b1, 32'h11, 1'b1, 1'b0};
        vecs[1] = '{2'b10, 32'h33, 1'b1, 1'b0, 1'b1, 32'h22, 1'b1, 1'b0};
        vecs[2] = '{2'b00, 32'h33, 1'b1, 1'b0, 1'b1, 32'h33, 1'b0, 1'b0};
        vecs[3] = '{2'b11, 32'hAA, 1'b1, 1'b0, 1'b1, 32'hAA, 1'b0, 1'b1};
        vecs[4] = '{2'b01, 32'h33, 1'b0, 1'b0, 1'b0, 32'hAA, 1'b0, 1'b1};
        vecs[5] = '{2'b01, 32'h33, 1'b1, 1'b1, 1'b0, 32'hAA, 1'b0, 1'b0};

        rst = 1'b1; src_sel = '0; src_data = '0; dflt = '0; pc_plus_4 = '0;
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_outputs("reset");
        chk("reset.in_ready", 64'(in_ready), 64'd1);

        // Directed table
        for (int i = 0; i < 6; i++) begin
            step(vecs[i].sel, 32'h11, 32'h22, vecs[i].dflt, 32'h1000 + i,
                 vecs[i].iv, 1'b1, vecs[i].fl);
            chk($sformatf("vec%0d.valid", i), 64'(out_valid), 64'(vecs[i].exp_valid));
            chk($sformatf("vec%0d.data", i),  64'(out_data),  64'(vecs[i].exp_data));
            chk($sformatf("vec%0d.fwd", i),   64'(out_fwd),   64'(vecs[i].exp_fwd));
            chk($sformatf("vec%0d.err", i),   64'(sel_err),   64'(vecs[i].exp_err));
        end

        // Stall: load 0x55 then hold out_ready low while inputs change
        step(2'b01, 32'h55, 32'h0, 32'h0, 32'h2000, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(2'b10, $urandom, $urandom, $urandom, $urandom, 1'b1, 1'b0, 1'b0);
            chk("stall.data", 64'(out_data), 64'h55);
            chk("stall.valid", 64'(out_valid), 64'd1);
            chk("stall.in_ready", 64'(in_ready), 64'd0);
        end

        // Back-to-back 1..8
        for (int v = 1; v <= 8; v++) begin
            step(2'b01, 32'(v), 32'h0, 32'h0, 32'h3000 + v, 1'b1, 1'b1, 1'b0);
            chk("b2b.data", 64'(out_data), 64'(v));
            chk("b2b.valid", 64'(out_valid), 64'd1);
        end

        // Flush with a simultaneous transfer-in while full
        step(2'b01, 32'h77, 32'h0, 32'h0, 32'h4000, 1'b1, 1'b1, 1'b1);
        chk("flush.valid", 64'(out_valid), 64'd0);
        step(2'b01, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        chk("flush.valid2", 64'(out_valid), 64'd0);
        chk("flush.data_not_flushed", 64'(out_data), 64'd8);

        // Asynchronous reset mid-stall
        step(2'b01, 32'h55, 32'h0, 32'h0, 32'h5000, 1'b1, 1'b1, 1'b0);
        step(2'b10, 32'h0, 32'h99, 32'h0, 32'h5004, 1'b1, 1'b0, 1'b0);
        chk("prereset.data", 64'(out_data), 64'h55);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs("async_rst");
        chk("async_rst.data", 64'(out_data), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Three forwards and one error
        step(2'b01, 32'h1, 32'h2, 32'h3, 32'h6000, 1'b1, 1'b1, 1'b0);
        step(2'b10, 32'h1, 32'h2, 32'h3, 32'h6004, 1'b1, 1'b1, 1'b0);
        step(2'b11, 32'h1, 32'h2, 32'h3, 32'h6008, 1'b1, 1'b1, 1'b0);
        step(2'b01, 32'h1, 32'h2, 32'h3, 32'h600C, 1'b1, 1'b1, 1'b0);
`ifdef FWD_OPERAND_STATS_EN
        chk("stats.fwd_cnt", 64'(fwd_cnt), 64'd3);
        chk("stats.err_cnt", 64'(err_cnt), 64'd1);
`endif

        // Randomized run against the model
        for (int i = 0; i < 400; i++) begin
            step(2'($urandom_range(0, 3)), $urandom, $urandom, $urandom, $urandom,
                 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 9) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
